wb_arb_bus: RTL and testbench

Parametrised Wishbone classic interconnect sitting between N bus masters (6502 bridge, DMA/debug masters) and M memory-mapped slaves (RAM, PIA, TIA, ROM). It arbitrates masters round-robin, decodes the granted master's address against per-slave value/mask pairs, routes strobe/write/data to one slave and routes ack/read data back. A watchdog terminates accesses that no slave answers, so one bad address cannot hang the system.

---
 rtl/wb_arb_bus_if.sv | 23 ++
 rtl/wb_arb_bus.sv | 97 +++++++++
 tb/tb_wb_arb_bus.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_bus_if.sv
// wb_arb_bus_if: master-side and slave-side Wishbone classic signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_arb_bus_if #(
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int N  = 2,
    parameter int M  = 4
);
    logic [N-1:0]    mstr_stb_i, mstr_we_i, mstr_ack_o, mstr_err_o;
    logic [N*AW-1:0] mstr_adr_i;
    logic [N*DW-1:0] mstr_dat_i, mstr_dat_o;
    logic [M-1:0]    slv_stb_o, slv_we_o, slv_ack_i;
    logic [M*AW-1:0] slv_adr_o;
    logic [M*DW-1:0] slv_dat_o, slv_dat_i;
    modport slave (
        input  mstr_stb_i, mstr_we_i, mstr_adr_i, mstr_dat_i, slv_ack_i, slv_dat_i,
        output mstr_ack_o, mstr_err_o, mstr_dat_o, slv_stb_o, slv_we_o, slv_adr_o, slv_dat_o
    );
    modport master (
        output mstr_stb_i, mstr_we_i, mstr_adr_i, mstr_dat_i, slv_ack_i, slv_dat_i,
        input  mstr_ack_o, mstr_err_o, mstr_dat_o, slv_stb_o, slv_we_o, slv_adr_o, slv_dat_o
    );
endinterface

// File: rtl/wb_arb_bus.sv
// wb_arb_bus: round-robin N-master / M-slave Wishbone classic interconnect with address decode.
// WB_ARB_BUS_TIMEOUT_EN enables the watchdog; without it unmapped accesses error immediately.
module wb_arb_bus #(
    parameter int WB_DATA_WIDTH  = 8,
    parameter int WB_ADDR_WIDTH  = 16,
    parameter int WB_NUM_MASTERS = 2,
    parameter int WB_NUM_SLAVES  = 4,
    parameter int TIMEOUT_CYCLES = 15,
    parameter logic [WB_DATA_WIDTH-1:0] DEFAULT_DATA = '1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic [WB_NUM_SLAVES*WB_ADDR_WIDTH-1:0] bus_slv_addr_decode_value,
    input  logic [WB_NUM_SLAVES*WB_ADDR_WIDTH-1:0] bus_slv_addr_decode_mask,
    wb_arb_bus_if.slave bus
);
    localparam int DW = WB_DATA_WIDTH;
    localparam int AW = WB_ADDR_WIDTH;
    localparam int N  = WB_NUM_MASTERS;
    localparam int M  = WB_NUM_SLAVES;
    localparam int GW = N > 1 ? $clog2(N) : 1;
    localparam int SW = M > 1 ? $clog2(M) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [GW-1:0] r_grant, r_last, w_grant;
    logic [SW-1:0] r_hit, w_hit;
    logic [AW-1:0] w_adr;
    logic r_mapped, w_mapped, w_req, w_stb, w_live, w_sack, w_err, w_done;
    // Search starts just after the last completed grant, so the nearest requester wins.
    always_comb begin
        w_req   = 1'b0;
        w_grant = r_last;
        for (int k = N; k >= 1; k--) begin
            if (bus.mstr_stb_i[(int'(r_last) + k) % N]) begin
                w_req   = 1'b1;
                w_grant = GW'((int'(r_last) + k) % N);
            end
        end
        w_adr    = bus.mstr_adr_i[int'(w_grant)*AW +: AW];
        w_mapped = 1'b0;
        w_hit    = '0;
        for (int j = M - 1; j >= 0; j--) begin
            if ((w_adr & bus_slv_addr_decode_mask[j*AW +: AW]) == bus_slv_addr_decode_value[j*AW +: AW]) begin
                w_mapped = 1'b1;
                w_hit    = SW'(j);
            end
        end
    end
    assign w_stb  = bus.mstr_stb_i[r_grant];
    assign w_live = (r_state == BUSY) & w_stb;
    assign w_sack = r_mapped & bus.slv_ack_i[r_hit];
`ifdef WB_ARB_BUS_TIMEOUT_EN
    logic [7:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) r_cnt <= '0;
        else r_cnt <= (r_state != BUSY) ? 8'd0 : (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    // r_cnt holds the number of completed BUSY cycles, so the limit hits on BUSY cycle TIMEOUT_CYCLES.
    assign w_err = w_live & ~w_sack & (r_cnt >= 8'(TIMEOUT_CYCLES - 1));
`else
    assign w_err = w_live & ~r_mapped;
`endif
    assign w_done = w_live & (w_sack | w_err);
    always_comb begin
        w_next = r_state == IDLE ? (w_req ? BUSY : IDLE) :
                 r_state == BUSY ? (!w_stb ? IDLE : w_done ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_last   <= GW'(N - 1);
            r_hit    <= '0;
            r_mapped <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_grant  <= w_grant;
                r_hit    <= w_hit;
                r_mapped <= w_mapped;
            end
            if (r_state == DONE) r_last <= r_grant;
        end
    always_comb begin
        bus.slv_stb_o        = '0;
        bus.slv_stb_o[r_hit] = w_live & r_mapped;
        bus.slv_we_o         = {M{w_live & bus.mstr_we_i[r_grant]}};
        bus.slv_adr_o        = {M{bus.mstr_adr_i[int'(r_grant)*AW +: AW]}};
        bus.slv_dat_o        = {M{bus.mstr_dat_i[int'(r_grant)*DW +: DW]}};
        bus.mstr_ack_o          = '0;
        bus.mstr_err_o          = '0;
        bus.mstr_dat_o          = {N{DEFAULT_DATA}};
        bus.mstr_ack_o[r_grant] = w_done;
        bus.mstr_err_o[r_grant] = w_err;
        bus.mstr_dat_o[int'(r_grant)*DW +: DW] = (w_live & r_mapped & ~w_err) ?
                                                 bus.slv_dat_i[int'(r_hit)*DW +: DW] : DEFAULT_DATA;
    end
endmodule

// File: tb/tb_wb_arb_bus.sv
// tb_wb_arb_bus: directed and randomized checks of wb_arb_bus against a transaction-level model.
module tb_wb_arb_bus;
    localparam int DW = 8, AW = 16, N = 2, M = 4, TO = 15;
`ifdef WB_ARB_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [M*AW-1:0] dv, dm;
    int lat [M];
    int scnt [M];
    logic [DW-1:0] rd [M];
    logic [M-1:0] mute;
    int checks = 0, errors = 0;
    wb_arb_bus_if #(.DW(DW), .AW(AW), .N(N), .M(M)) bus ();
    wb_arb_bus #(
        .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_NUM_MASTERS(N),
        .WB_NUM_SLAVES(M), .TIMEOUT_CYCLES(TO), .DEFAULT_DATA(8'hFF)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .bus_slv_addr_decode_value(dv), .bus_slv_addr_decode_mask(dm),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // Slave models: ack once strobed for lat[j] prior cycles, unless muted.
    always @(posedge clk or negedge rst_n)
        for (int j = 0; j < M; j++) scnt[j] <= (!rst_n || !bus.slv_stb_o[j]) ? 0 : scnt[j] + 1;
    always_comb begin
        bus.slv_ack_i = '0;
        bus.slv_dat_i = '0;
        for (int j = 0; j < M; j++) begin
            bus.slv_ack_i[j] = bus.slv_stb_o[j] & ~mute[j] & (scnt[j] >= lat[j]);
            bus.slv_dat_i[j*DW +: DW] = rd[j];
        end
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic int decode(input logic [AW-1:0] a);
        for (int j = 0; j < M; j++) if ((a & dm[j*AW +: AW]) == dv[j*AW +: AW]) return j;
        return -1;
    endfunction
    function automatic int exp_cycles(input int h);
        if (h < 0) return TMO_EN ? TO : 1;
        return mute[h] ? TO : 1 + lat[h];
    endfunction
    task automatic cfg_default();
        dv = {16'h0200, 16'h0080, 16'h0000, 16'hF000};
        dm = {16'hFF00, 16'hFF80, 16'hFF80, 16'hF000};
    endtask
    // One single-master transaction starting from IDLE, checked cycle by cycle.
    task automatic xact(input int m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        int h, ne, n;
        logic [M-1:0] se;
        logic bad;
        h   = decode(a);
        ne  = exp_cycles(h);
        se  = (h >= 0) ? M'(1) << h : '0;
        bad = (h < 0) || mute[h];
        bus.mstr_adr_i[m*AW +: AW] = a;
        bus.mstr_we_i[m] = w;
        bus.mstr_dat_i[m*DW +: DW] = d;
        bus.mstr_stb_i[m] = 1'b1;
        @(negedge clk);
        chk("arb_wait", {bus.mstr_ack_o, bus.slv_stb_o}, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("slv_stb", bus.slv_stb_o, se);
            if (n == 1) begin
                chk("slv_adr", bus.slv_adr_o, {M{a}});
                chk("slv_dat", bus.slv_dat_o, {M{d}});
                chk("slv_we", bus.slv_we_o, {M{w}});
            end
        end while (!bus.mstr_ack_o[m] && n < ne + 3);
        chk("ack_cycle", n, ne);
        chk("ack_vec", bus.mstr_ack_o, N'(1) << m);
        chk("err_vec", bus.mstr_err_o, bad ? N'(1) << m : '0);
        chk("rdata", bus.mstr_dat_o[m*DW +: DW], bad ? 8'hFF : rd[h]);
        chk("other_dat", bus.mstr_dat_o[(1-m)*DW +: DW], 8'hFF);
        @(posedge clk);
        #1 bus.mstr_stb_i[m] = 1'b0;
        @(negedge clk);
        chk("done_quiet", {bus.mstr_ack_o, bus.mstr_err_o, bus.slv_stb_o}, '0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end
    initial begin
        int m, sel, g;
        logic [AW-1:0] a;
        logic [N-1:0] e;
        cfg_default();
        mute = '0;
        for (int j = 0; j < M; j++) begin lat[j] = 0; rd[j] = 8'h00; end
        bus.mstr_stb_i = '0; bus.mstr_we_i = '0; bus.mstr_adr_i = '0; bus.mstr_dat_i = '0;
        @(negedge clk);
        chk("rst_slv_stb", bus.slv_stb_o, '0);
        chk("rst_ack", bus.mstr_ack_o, '0);
        chk("rst_err", bus.mstr_err_o, '0);
        chk("rst_dat", bus.mstr_dat_o, {N{8'hFF}});
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat[0] = 1; rd[0] = 8'hA9;
        xact(0, 16'hF123, 1'b0, 8'h00);
        dv = {16'h0200, 16'h0080, 16'h0080, 16'h0080};
        dm = {16'hFF00, 16'hFF80, 16'hFF80, 16'hFF80};
        lat[0] = 0;
        xact(1, 16'h0085, 1'b1, 8'h5A);
        cfg_default();
        xact(0, 16'h1000, 1'b0, 8'h00);
`ifdef WB_ARB_BUS_TIMEOUT_EN
        mute[1] = 1'b1;
        xact(1, 16'h0010, 1'b0, 8'h00);
        mute = '0;
`endif
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < M; j++) begin lat[j] = $urandom_range(0, 3); rd[j] = DW'($urandom); end
`ifdef WB_ARB_BUS_TIMEOUT_EN
            mute = ($urandom_range(0, 7) == 0) ? M'(1) << $urandom_range(0, M - 1) : '0;
`endif
            m   = $urandom_range(0, N - 1);
            sel = $urandom_range(0, 4);
            a   = sel == 0 ? {4'hF, 12'($urandom)} : sel == 1 ? {9'h000, 7'($urandom)} :
                  sel == 2 ? {9'h001, 7'($urandom)} : sel == 3 ? {8'h02, 8'($urandom)} : 16'($urandom);
            xact(m, a, 1'($urandom), DW'($urandom));
        end
        mute = '0;
        for (int j = 0; j < M; j++) lat[j] = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mstr_adr_i = {16'h0010, 16'hF000};
        bus.mstr_we_i  = '0;
        bus.mstr_stb_i = 2'b11;
        g = N - 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = '0;
            if (c % 3 == 1) begin g = (g + 1) % N; e[g] = 1'b1; end
            chk("rr_ack", bus.mstr_ack_o, e);
        end
        @(posedge clk);
        #1 bus.mstr_stb_i = '0;
        lat[3] = 10; rd[0] = 8'h3C;
        bus.mstr_adr_i = {16'hF000, 16'h0210};
        bus.mstr_stb_i = 2'b11;
        @(negedge clk);
        chk("abort_arb", bus.slv_stb_o, '0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_busy", bus.slv_stb_o, 4'b1000);
        end
        @(posedge clk);
        #1 bus.mstr_stb_i[0] = 1'b0;
        @(negedge clk);
        chk("abort_quiet", {bus.mstr_ack_o, bus.mstr_err_o, bus.slv_stb_o}, '0);
        @(negedge clk);
        chk("abort_idle", {bus.mstr_ack_o, bus.mstr_err_o, bus.slv_stb_o}, '0);
        @(negedge clk);
        chk("abort_next_stb", bus.slv_stb_o, 4'b0001);
        chk("abort_next_ack", bus.mstr_ack_o, 2'b10);
        chk("abort_next_dat", bus.mstr_dat_o[DW +: DW], 8'h3C);
        @(posedge clk);
        #1 bus.mstr_stb_i = '0;
        @(posedge clk);
        #1 bus.mstr_adr_i = {16'hF000, 16'h0210};
        bus.mstr_stb_i = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre", bus.slv_stb_o, 4'b1000);
        rst_n = 1'b0;
        #1 chk("rst_async", {bus.mstr_ack_o, bus.mstr_err_o, bus.slv_stb_o}, '0);
        bus.mstr_stb_i = 2'b11;
        lat[3] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_arb", bus.mstr_ack_o, '0);
        @(negedge clk);
        chk("rst_first_ack", bus.mstr_ack_o, 2'b01);
        chk("rst_first_stb", bus.slv_stb_o, 4'b1000);
        @(posedge clk);
        #1 bus.mstr_stb_i = '0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
